// File: rtl/exe_stage.sv
// Execute stage: operand-2 generation, ALU with NZCV flags, branch target
// adder, status register and the EX/MEM pipeline register.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [3:0]  exe_cmd_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        wb_enable_in,
  input  logic        status_update_in,
  input  logic        branch_taken_in,
  input  logic        imm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  dest_reg_in,
  input  logic [31:0] val_rn_in,
  input  logic [31:0] val_rm_in,
  input  logic [31:0] pc_in,
  output logic        branch_taken_out,
  output logic [31:0] branch_address,
  output logic [3:0]  status_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] val_rm_out,
  output logic [3:0]  dest_reg_out,
  output logic        wb_enable_out,
  output logic        mem_read_out,
  output logic        mem_write_out
);

  logic [31:0] w_val2;
  logic [63:0] w_dbl;
  logic [4:0]  w_rot_imm;
  logic [4:0]  w_shamt;
  logic [31:0] w_result;
  logic [32:0] w_sum;
  logic        w_valid;
  logic        w_flag_n;
  logic        w_flag_z;
  logic        w_flag_c;
  logic        w_flag_v;
  logic        w_carry_in;

  logic [3:0]  r_status;
  logic [31:0] r_alu_result;
  logic [31:0] r_val_rm;
  logic [3:0]  r_dest_reg;
  logic        r_wb_enable;
  logic        r_mem_read;
  logic        r_mem_write;

  // Branch path is purely combinational so IF can redirect in the same cycle.
  assign branch_taken_out = branch_taken_in;
  assign branch_address   = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

  assign w_rot_imm  = {shift_operand_in[11:8], 1'b0};
  assign w_shamt    = shift_operand_in[11:7];
  assign w_carry_in = r_status[1];

  // Operand-2 generation; rotates use a doubled word so amount 0 is a pass-through.
  always_comb begin
    w_val2 = '0;
    w_dbl  = '0;
    if (imm_in) begin
      w_dbl  = {24'd0, shift_operand_in[7:0], 24'd0, shift_operand_in[7:0]} >> w_rot_imm;
      w_val2 = w_dbl[31:0];
    end else if (mem_read_in || mem_write_in) begin
      w_val2 = {20'd0, shift_operand_in};
    end else begin
      case (shift_operand_in[6:5])
        2'b00:   w_val2 = val_rm_in << w_shamt;
        2'b01:   w_val2 = val_rm_in >> w_shamt;
        2'b10:   w_val2 = $signed(val_rm_in) >>> w_shamt;
        default: begin
          w_dbl  = {val_rm_in, val_rm_in} >> w_shamt;
          w_val2 = w_dbl[31:0];
        end
      endcase
    end
  end

  // ALU and flag generation; subtraction is Rn + ~Val2 + carry so C means "no borrow".
  always_comb begin
    w_result = '0;
    w_sum    = '0;
    w_valid  = 1'b0;
    w_flag_n = r_status[3];
    w_flag_z = r_status[2];
    w_flag_c = r_status[1];
    w_flag_v = r_status[0];
    case (exe_cmd_in)
      4'b0001: begin w_result = w_val2;              w_valid = 1'b1; end
      4'b1001: begin w_result = ~w_val2;             w_valid = 1'b1; end
      4'b0110: begin w_result = val_rn_in & w_val2;  w_valid = 1'b1; end
      4'b0111: begin w_result = val_rn_in | w_val2;  w_valid = 1'b1; end
      4'b1000: begin w_result = val_rn_in ^ w_val2;  w_valid = 1'b1; end
      4'b0010, 4'b0011: begin
        w_sum    = {1'b0, val_rn_in} + {1'b0, w_val2}
                 + {32'd0, (exe_cmd_in[0] & w_carry_in)};
        w_result = w_sum[31:0];
        w_flag_c = w_sum[32];
        w_flag_v = (val_rn_in[31] == w_val2[31]) && (w_result[31] != val_rn_in[31]);
        w_valid  = 1'b1;
      end
      4'b0100, 4'b0101: begin
        w_sum    = {1'b0, val_rn_in} + {1'b0, ~w_val2}
                 + {32'd0, (exe_cmd_in[0] ? w_carry_in : 1'b1)};
        w_result = w_sum[31:0];
        w_flag_c = w_sum[32];
        w_flag_v = (val_rn_in[31] != w_val2[31]) && (w_result[31] != val_rn_in[31]);
        w_valid  = 1'b1;
      end
      default: begin end
    endcase
    if (w_valid) begin
      w_flag_n = w_result[31];
      w_flag_z = (w_result == 32'd0);
    end
  end

  // NZCV register: written only by flag-setting instructions that are not stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status <= 4'b0000;
    end else if (!freeze && status_update_in) begin
      r_status <= {w_flag_n, w_flag_z, w_flag_c, w_flag_v};
    end
  end

  // EX/MEM pipeline register, held while the pipeline is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_result <= '0;
      r_val_rm     <= '0;
      r_dest_reg   <= '0;
      r_wb_enable  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else if (!freeze) begin
      r_alu_result <= w_result;
      r_val_rm     <= val_rm_in;
      r_dest_reg   <= dest_reg_in;
      r_wb_enable  <= wb_enable_in;
      r_mem_read   <= mem_read_in;
      r_mem_write  <= mem_write_in;
    end
  end

  assign status_out     = r_status;
  assign alu_result_out = r_alu_result;
  assign val_rm_out     = r_val_rm;
  assign dest_reg_out   = r_dest_reg;
  assign wb_enable_out  = r_wb_enable;
  assign mem_read_out   = r_mem_read;
  assign mem_write_out  = r_mem_write;

endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage with hand-computed expected values.
module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic [3:0]  exe_cmd_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        wb_enable_in;
  logic        status_update_in;
  logic        branch_taken_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_reg_in;
  logic [31:0] val_rn_in;
  logic [31:0] val_rm_in;
  logic [31:0] pc_in;
  logic        branch_taken_out;
  logic [31:0] branch_address;
  logic [3:0]  status_out;
  logic [31:0] alu_result_out;
  logic [31:0] val_rm_out;
  logic [3:0]  dest_reg_out;
  logic        wb_enable_out;
  logic        mem_read_out;
  logic        mem_write_out;

  int n_checks = 0;
  int n_pass   = 0;

  exe_stage dut (
    .clk              (clk),
    .rst              (rst),
    .freeze           (freeze),
    .exe_cmd_in       (exe_cmd_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .wb_enable_in     (wb_enable_in),
    .status_update_in (status_update_in),
    .branch_taken_in  (branch_taken_in),
    .imm_in           (imm_in),
    .shift_operand_in (shift_operand_in),
    .signed_imm_24_in (signed_imm_24_in),
    .dest_reg_in      (dest_reg_in),
    .val_rn_in        (val_rn_in),
    .val_rm_in        (val_rm_in),
    .pc_in            (pc_in),
    .branch_taken_out (branch_taken_out),
    .branch_address   (branch_address),
    .status_out       (status_out),
    .alu_result_out   (alu_result_out),
    .val_rm_out       (val_rm_out),
    .dest_reg_out     (dest_reg_out),
    .wb_enable_out    (wb_enable_out),
    .mem_read_out     (mem_read_out),
    .mem_write_out    (mem_write_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports each check.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-14s got=%08h exp=%08h ok", tag, got, exp);
    end else begin
      $display("FAIL %-14s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic imm, input logic mr, input logic mw,
                        input logic wb, input logic s, input logic [11:0] so,
                        input logic [31:0] rn, input logic [31:0] rm, input logic [3:0] dst);
    exe_cmd_in       = cmd;
    imm_in           = imm;
    mem_read_in      = mr;
    mem_write_in     = mw;
    wb_enable_in     = wb;
    status_update_in = s;
    shift_operand_in = so;
    val_rn_in        = rn;
    val_rm_in        = rm;
    dest_reg_in      = dst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_alu"},  alu_result_out, 32'd0);
    chk({pfx, "_stat"}, {28'd0, status_out}, 32'd0);
    chk({pfx, "_rm"},   val_rm_out, 32'd0);
    chk({pfx, "_dst"},  {28'd0, dest_reg_out}, 32'd0);
    chk({pfx, "_ctl"},  {29'd0, wb_enable_out, mem_read_out, mem_write_out}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    freeze = 1'b0;
    branch_taken_in = 1'b0;
    signed_imm_24_in = 24'd0;
    pc_in = 32'd0;
    set_op(4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF, 32'h1234, 32'h5678, 4'hF);
    #2;
    chk_all_zero("rst");
    @(negedge clk);
    rst = 1'b1;

    // Rotated immediates on consecutive cycles
    set_op(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h014, 32'd0, 32'd0, 4'd0);
    tick();
    chk("imm_014", alu_result_out, 32'h0000_0014);
    chk("imm_wb", {31'd0, wb_enable_out}, 32'd1);
    chk("imm_dst0", {28'd0, dest_reg_out}, 32'd0);
    set_op(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'hA01, 32'd0, 32'd0, 4'd1);
    tick();
    chk("imm_A01", alu_result_out, 32'h0000_1000);
    chk("imm_dst1", {28'd0, dest_reg_out}, 32'd1);
    set_op(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h103, 32'd0, 32'd0, 4'd2);
    tick();
    chk("imm_103", alu_result_out, 32'hC000_0000);
    chk("imm_dst2", {28'd0, dest_reg_out}, 32'd2);
    chk("imm_nostat", {28'd0, status_out}, 32'd0);

    // ADDS with carry out: 0xC0000000 + 0xC0000000
    set_op(4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h103, 32'hC000_0000, 32'd0, 4'd3);
    tick();
    chk("adds_res", alu_result_out, 32'h8000_0000);
    chk("adds_nzcv", {28'd0, status_out}, 32'hA);

    // CMP 5,5 then SBC / ADC consuming C=1
    set_op(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h005, 32'd5, 32'd0, 4'd4);
    tick();
    chk("cmp_nzcv", {28'd0, status_out}, 32'h6);
    chk("cmp_wb", {31'd0, wb_enable_out}, 32'd0);
    set_op(4'b0101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h003, 32'd10, 32'd0, 4'd5);
    tick();
    chk("sbc_c1", alu_result_out, 32'd7);
    chk("sbc_keepst", {28'd0, status_out}, 32'h6);
    set_op(4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h002, 32'd1, 32'd0, 4'd5);
    tick();
    chk("adc_c1", alu_result_out, 32'd4);

    // Clear C with ADDS 1+1, then SBC and ADC see C=0
    set_op(4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h001, 32'd1, 32'd0, 4'd6);
    tick();
    chk("adds_small", alu_result_out, 32'd2);
    chk("adds_nzcv0", {28'd0, status_out}, 32'h0);
    set_op(4'b0101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h003, 32'd10, 32'd0, 4'd6);
    tick();
    chk("sbc_c0", alu_result_out, 32'd6);
    set_op(4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h002, 32'd1, 32'd0, 4'd6);
    tick();
    chk("adc_c0", alu_result_out, 32'd3);

    // Signed overflow: 0x7FFFFFFF + 1 -> N=1 Z=0 C=0 V=1
    set_op(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 32'h7FFF_FFFF, 32'd1, 4'd7);
    tick();
    chk("adds_ovf", alu_result_out, 32'h8000_0000);
    chk("adds_ovf_st", {28'd0, status_out}, 32'h9);

    // Register-shifted operand 2 on 0x80000001
    set_op(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0C0, 32'd0, 32'h8000_0001, 4'd8);
    tick();
    chk("asr1", alu_result_out, 32'hC000_0000);
    set_op(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0E0, 32'd0, 32'h8000_0001, 4'd8);
    tick();
    chk("ror1", alu_result_out, 32'hC000_0000);
    set_op(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0A0, 32'd0, 32'h8000_0001, 4'd8);
    tick();
    chk("lsr1", alu_result_out, 32'h4000_0000);
    set_op(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h080, 32'd0, 32'h8000_0001, 4'd8);
    tick();
    chk("lsl1", alu_result_out, 32'h0000_0002);
    set_op(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h060, 32'd0, 32'h8000_0001, 4'd8);
    tick();
    chk("ror0", alu_result_out, 32'h8000_0001);

    // Loads/stores: 12-bit zero-extended offset, store data forwarded
    set_op(4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'hFFF, 32'h0000_1000, 32'hDEAD_BEEF, 4'd9);
    tick();
    chk("ldr_addr", alu_result_out, 32'h0000_1FFF);
    chk("ldr_ctl", {29'd0, wb_enable_out, mem_read_out, mem_write_out}, 32'h6);
    chk("ldr_rm", val_rm_out, 32'hDEAD_BEEF);
    set_op(4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h804, 32'h0000_0100, 32'h1234_5678, 4'd10);
    tick();
    chk("str_addr", alu_result_out, 32'h0000_0904);
    chk("str_ctl", {29'd0, wb_enable_out, mem_read_out, mem_write_out}, 32'h1);

    // Logical ops, MVN and an undefined opcode
    set_op(4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0FF, 32'd0, 32'd0, 4'd11);
    tick();
    chk("mvn", alu_result_out, 32'hFFFF_FF00);
    set_op(4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0F0, 32'h0000_0FFF, 32'd0, 4'd11);
    tick();
    chk("and", alu_result_out, 32'h0000_00F0);
    set_op(4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0F0, 32'h0000_000F, 32'd0, 4'd11);
    tick();
    chk("orr", alu_result_out, 32'h0000_00FF);
    set_op(4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0FF, 32'h0000_0F0F, 32'd0, 4'd11);
    tick();
    chk("eor", alu_result_out, 32'h0000_0FF0);
    set_op(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0FF, 32'h1234_5678, 32'd0, 4'd11);
    tick();
    chk("bad_op", alu_result_out, 32'd0);
    chk("bad_op_st", {28'd0, status_out}, 32'h9);

    // Branch target is combinational
    branch_taken_in  = 1'b1;
    pc_in            = 32'h0000_0020;
    signed_imm_24_in = 24'hFFFFFD;
    #1;
    chk("br_back", branch_address, 32'h0000_0014);
    chk("br_taken", {31'd0, branch_taken_out}, 32'd1);
    pc_in            = 32'h0000_0100;
    signed_imm_24_in = 24'h000004;
    branch_taken_in  = 1'b0;
    #1;
    chk("br_fwd", branch_address, 32'h0000_0110);
    chk("br_nottk", {31'd0, branch_taken_out}, 32'd0);

    // CMP 3,5 -> 0xFFFFFFFE, NZCV=1000, then freeze for 3 cycles
    set_op(4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h005, 32'd3, 32'hAAAA_5555, 4'd12);
    tick();
    chk("cmp_neg", alu_result_out, 32'hFFFF_FFFE);
    chk("cmp_neg_st", {28'd0, status_out}, 32'h8);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h010 + 12'(i), 32'd0, 32'(i), 4'(i));
      tick();
      chk("frz_alu", alu_result_out, 32'hFFFF_FFFE);
      chk("frz_stat", {28'd0, status_out}, 32'h8);
      chk("frz_dst", {28'd0, dest_reg_out}, 32'd12);
    end

    // Asynchronous reset in the middle of the freeze
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rstfrz");
    @(negedge clk);
    rst = 1'b1;
    freeze = 1'b0;
    set_op(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h014, 32'd0, 32'd0, 4'd13);
    tick();
    chk("resume", alu_result_out, 32'h0000_0014);
    chk("resume_dst", {28'd0, dest_reg_out}, 32'd13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
